// File: rtl/calc_arb_pkg.sv
// Shared types and constants for the calculator arbiter: FSM state encoding,
// ALU op codes and the default watchdog limit.
package calc_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GO   = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [1:0] ADD_OP = 2'b11;
  localparam logic [1:0] SUB_OP = 2'b10;
  localparam logic [1:0] AND_OP = 2'b01;
  localparam logic [1:0] XOR_OP = 2'b00;

  localparam int DEFAULT_TIMEOUT = 15;

  // Index width for n requesters, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/calc_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after ptr_i,
// wrapping around, reported both one-hot and as an index.
module rr_pick
  import calc_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] onehot_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_req_o
);

  logic          found;
  logic [IW-1:0] pos;

  // NOTE: every variable written here gets a default before any branch, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    onehot_o  = '0;
    idx_o     = '0;
    found     = 1'b0;
    pos       = '0;
    any_req_o = |req_i;
    for (int k = 1; k <= NREQ; k++) begin
      pos = IW'((int'(ptr_i) + k) % NREQ);
      if (!found && req_i[pos]) begin
        found         = 1'b1;
        onehot_o[pos] = 1'b1;
        idx_o         = pos;
      end
    end
  end

endmodule

// File: rtl/calc_arbiter.sv
// Round-robin arbiter sharing one calculator among NREQ requesters, with a
// watchdog that aborts a transaction when Done never arrives.
module calc_arbiter
  import calc_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DW      = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] in1_flat,
  input  logic [NREQ*DW-1:0] in2_flat,
  input  logic [NREQ*2-1:0] op_flat,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [DW-1:0]     rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              calc_go,
  output logic [1:0]        calc_op,
  output logic [DW-1:0]     calc_in1,
  output logic [DW-1:0]     calc_in2,
  input  logic              calc_done,
  input  logic [DW-1:0]     calc_out,
  output logic              calc_abort
);

  localparam int IW = idx_width(NREQ);
  localparam int CW = $clog2(TIMEOUT);

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   win_q, win_d;
  logic [NREQ-1:0] win_oh_q, win_oh_d;
  logic [DW-1:0]   in1_q, in1_d, in2_q, in2_d, res_q, res_d;
  logic [1:0]      op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;

  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            any_req;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .onehot_o  (pick_oh),
    .idx_o     (pick_idx),
    .any_req_o (any_req)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; reset is synchronous and checked first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= IW'(NREQ - 1);
      win_q    <= '0;
      win_oh_q <= '0;
      in1_q    <= '0;
      in2_q    <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      win_oh_q <= win_oh_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    win_oh_d = win_oh_q;
    in1_d    = in1_q;
    in2_d    = in2_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    err_d    = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          win_d    = pick_idx;
          win_oh_d = pick_oh;
          in1_d    = in1_flat[pick_idx*DW +: DW];
          in2_d    = in2_flat[pick_idx*DW +: DW];
          op_d     = op_flat[pick_idx*2 +: 2];
          state_d  = ST_GO;
        end
      end
      ST_GO: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Done has priority over the watchdog when both land in one cycle.
        if (calc_done) begin
          res_d   = calc_out;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RESP: begin
        ptr_d   = win_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic active;
  assign active     = (state_q == ST_GO) || (state_q == ST_WAIT);
  assign busy       = (state_q != ST_IDLE);
  assign gnt        = active ? win_oh_q : '0;
  assign calc_go    = (state_q == ST_GO);
  assign calc_op    = active ? op_q  : '0;
  assign calc_in1   = active ? in1_q : '0;
  assign calc_in2   = active ? in2_q : '0;
  assign rsp_valid  = (state_q == ST_RESP) ? win_oh_q : '0;
  assign rsp_data   = (state_q == ST_RESP) ? res_q : '0;
  assign rsp_err    = (state_q == ST_RESP) && err_q;
  assign calc_abort = (state_q == ST_RESP) && err_q;

endmodule

// File: doc/calc_arbiter.md
Name: calc_arbiter

Overview:
- Round-robin arbiter that shares one calculator unit (control FSM + register-file/ALU datapath) among NREQ requesters.
- Latches the winning requester's operands and op code.
- Pulses Go to the calculator, holds its inputs stable until Done, captures the result and returns it to that requester with a one-cycle response pulse.
- A watchdog aborts a transaction if Done never arrives.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 4, operand/result data width
- TIMEOUT, 15, max cycles spent in WAIT before abort (>=8)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request; held high until own rsp_valid
- in1_flat  in  NREQ*DW  operand 1 per requester; slice i = [i*DW +: DW]
- in2_flat  in  NREQ*DW  operand 2 per requester
- op_flat  in  NREQ*2  ALU op per requester (11 ADD, 10 SUB, 01 AND, 00 XOR)
- gnt  out  NREQ  one-hot grant; high from GO through WAIT
- rsp_valid  out  NREQ  one-cycle response pulse to the winner
- rsp_data  out  DW  result; valid only while any rsp_valid is high
- rsp_err  out  1  high with rsp_valid when the transaction timed out
- busy  out  1  high in any state other than IDLE
- calc_go  out  1  Go to calculator; exactly one cycle per transaction
- calc_op  out  2  op to calculator; held from GO through WAIT
- calc_in1  out  DW  operand 1 to calculator; held from GO through WAIT
- calc_in2  out  DW  operand 2 to calculator; held from GO through WAIT
- calc_done  in  1  Done from calculator
- calc_out  in  DW  calculator result; valid while calc_done is high
- calc_abort  out  1  one-cycle pulse on timeout; resets the calculator FSM

Behaviour:
- Reset:
  - state = IDLE; all outputs 0.
  - RR pointer = NREQ-1, so requester 0 wins first.
  - Latched operands, op and winner index cleared; watchdog counter = 0.
- States:
  - IDLE: if any req is high, pick the winner (search from ptr+1, wrapping), latch its in1/in2/op and index, go to GO. Otherwise stay.
  - GO: gnt[w]=1, calc_go=1, calc_* driven from latches; next state WAIT, watchdog counter cleared.
  - WAIT: gnt[w]=1, calc_go=0, calc_* held.
    - calc_done=1: capture calc_out, go to RESP with err=0.
    - Else if counter == TIMEOUT-1: go to RESP with err=1 and captured data 0.
    - Else increment counter.
  - RESP: rsp_valid[w]=1 and rsp_data = captured value; rsp_err and calc_abort = err; gnt=0; ptr = w; next IDLE.
- Latency:
  - With a nominal calculator (Done 5 cycles after Go is sampled), req seen in IDLE at cycle 0 → GO c1 → Done c6 → rsp_valid c7.
  - Back-to-back transactions start 8 cycles apart.
- Boundary conditions:
  - Requester inputs are sampled only in IDLE. Changes after the grant are ignored.
  - A requester dropping req mid-transaction is ignored; the transaction completes and the response still pulses.
  - calc_done and timeout in the same WAIT cycle: done wins (err=0, data captured).
  - calc_done outside WAIT is ignored.
  - Reset in any state returns to IDLE next cycle with all outputs 0. calc_abort is not pulsed (calculator shares the same reset).
  - Grant is combinational from req in IDLE but registered into the latches. gnt is never asserted for more than one requester.
  - The RR pointer updates only in RESP, including on timeout, so a hung requester cannot starve the others.

Decomposition:
- Package calc_arb_pkg:
  - state encoding (IDLE, GO, WAIT, RESP; 2 bits)
  - op-code constants ADD_OP=2'b11, SUB_OP=2'b10, AND_OP=2'b01, XOR_OP=2'b00
  - default TIMEOUT
- Sub-module rr_pick: purely combinational. Inputs req and ptr; outputs one-hot winner, index and any_req.

Test Plan:
- Single request: req[0]=1, in1=3, in2=5, op=ADD; calculator model returns 8 → gnt[0] high c1–c6, calc_go only c1, rsp_valid[0] at c7 with rsp_data=8, rsp_err=0.
- Contention: req=4'b1111 held after reset; each requester drops req after its own rsp_valid → grants 0,1,2,3 in order, rsp_valid pulses at c7, c15, c23, c31.
- Fairness: req[0] and req[2] held continuously for 6 transactions → grant order 0,2,0,2,0,2; gnt is never multi-hot.
- Timeout: calculator model never asserts Done, TIMEOUT=15 → exactly 15 WAIT cycles, then rsp_valid[w]=1 with rsp_err=1, rsp_data=0 and calc_abort pulsed once.
- Done/timeout collision: Done asserted on the 15th WAIT cycle with calc_out=4'hA → rsp_err=0, rsp_data=4'hA, calc_abort=0.
- Reset mid-WAIT: assert reset at c4 → at c5 all outputs are 0 and busy=0; next request from req=4'b0110 grants requester 1.
